// File: rtl/bus_decode_pkg.sv
// bus_decode_pkg: header opcode, serializer FSM encoding and wide-bus width helper
package bus_decode_pkg;
  localparam logic [7:0] CMD_DATA_TRAN = 8'hA5;
  typedef enum logic [2:0] {IDLE, HDR_OP, HDR_AL, HDR_AH, HDR_LEN, RD_REQ, RD_WAIT, SHIFT} state_t;
  function automatic int high_width(input int low_width, input int size_log);
    return low_width << size_log;
  endfunction
endpackage

// File: rtl/word_serializer.sv
// word_serializer: parallel-load one wide word and shift it out as narrow beats, LSB slice first
module word_serializer
  import bus_decode_pkg::*;
#(
  parameter int LOW_DATA_WIDTH = 8,
  parameter int BRUST_SIZE_LOG = 2,
  localparam int HIGH_DATA_WIDTH = high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [HIGH_DATA_WIDTH-1:0] word,
  input  logic                       ready,
  output logic                       valid,
  output logic [LOW_DATA_WIDTH-1:0]  data,
  output logic                       last_beat
);
  logic [HIGH_DATA_WIDTH-1:0] shreg;
  logic [BRUST_SIZE_LOG-1:0]  beat;
  assign data = shreg[LOW_DATA_WIDTH-1:0];
  assign last_beat = beat == {BRUST_SIZE_LOG{1'b1}};
  // load resets the beat count; each accepted beat drops the low slice, valid clears after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      beat  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= word;
      beat  <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      shreg <= shreg >> LOW_DATA_WIDTH;
      beat  <= beat + BRUST_SIZE_LOG'(1);
      valid <= !last_beat;
    end
  end
endmodule

// File: rtl/high_to_low.sv
// high_to_low: burst read command -> wide-bus word fetches -> framed narrow beat stream
module high_to_low
  import bus_decode_pkg::*;
#(
  parameter int LOW_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int BRUST_SIZE_LOG = 2,
  localparam int HIGH_DATA_WIDTH = high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [7:0]                 cmd_len,
  output logic                       high_read_req,
  output logic [ADDR_WIDTH-1:0]      high_read_addr,
  input  logic                       high_read_valid,
  input  logic [HIGH_DATA_WIDTH-1:0] high_read_data,
  output logic                       low_write_valid,
  input  logic                       low_write_ready,
  output logic [LOW_DATA_WIDTH-1:0]  low_write_data,
  output logic                       cmd_done
);
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [15:0]               addr16;
  logic [7:0]                len, word_idx;
  logic                      accept, hdr_valid, hdr_fire, ser_load, ser_valid, ser_fire, ser_last, last_word, done_next;
  logic [LOW_DATA_WIDTH-1:0] hdr_data, hdr_data_next, ser_data;
  assign addr16 = 16'(addr);
  assign low_write_valid = hdr_valid || ser_valid;
  assign low_write_data = hdr_valid ? hdr_data : ser_valid ? ser_data : '0;
  word_serializer #(.LOW_DATA_WIDTH(LOW_DATA_WIDTH), .BRUST_SIZE_LOG(BRUST_SIZE_LOG)) u_ser (
    .clk(clk), .rst_n(rst_n), .load(ser_load), .word(high_read_data), .ready(low_write_ready),
    .valid(ser_valid), .data(ser_data), .last_beat(ser_last)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  // next state, handshakes, read strobe and the header beat that goes with the next state
  always_comb begin
    state_next = state;
    done_next = 1'b0;
    cmd_ready = state == IDLE && !cmd_done;
    accept = cmd_valid && cmd_ready;
    high_read_req = state == RD_REQ;
    high_read_addr = high_read_req ? addr + ADDR_WIDTH'(word_idx) : '0;
    hdr_fire = hdr_valid && low_write_ready;
    ser_fire = ser_valid && low_write_ready;
    ser_load = state == RD_WAIT && high_read_valid;
    last_word = word_idx == len - 8'd1;
    case (state)
      IDLE: begin
        state_next = accept && cmd_len != 8'd0 ? HDR_OP : IDLE;
        done_next = accept && cmd_len == 8'd0;
      end
      HDR_OP:  state_next = hdr_fire ? HDR_AL : state;
      HDR_AL:  state_next = hdr_fire ? HDR_AH : state;
      HDR_AH:  state_next = hdr_fire ? HDR_LEN : state;
      HDR_LEN: state_next = hdr_fire ? RD_REQ : state;
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: state_next = high_read_valid ? SHIFT : state;
      SHIFT: begin
        state_next = ser_fire && ser_last ? (last_word ? IDLE : RD_REQ) : state;
        done_next = ser_fire && ser_last && last_word;
      end
    endcase
    hdr_data_next = state_next == HDR_OP  ? LOW_DATA_WIDTH'(CMD_DATA_TRAN) :
                    state_next == HDR_AL  ? LOW_DATA_WIDTH'(addr16[7:0]) :
                    state_next == HDR_AH  ? LOW_DATA_WIDTH'(addr16[15:8]) :
                    state_next == HDR_LEN ? LOW_DATA_WIDTH'(len) : '0;
  end
  // command latch, word counter, registered header beat and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      len       <= '0;
      word_idx  <= '0;
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
      cmd_done  <= 1'b0;
    end else begin
      cmd_done  <= done_next;
      hdr_valid <= state_next inside {HDR_OP, HDR_AL, HDR_AH, HDR_LEN};
      hdr_data  <= hdr_data_next;
      if (accept) begin
        addr     <= cmd_addr;
        len      <= cmd_len;
        word_idx <= '0;
      end else if (state == SHIFT && state_next == RD_REQ) begin
        word_idx <= word_idx + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_high_to_low.sv
// tb_high_to_low: scoreboard bench for the burst read serializer with a latency-programmable memory model
module tb_high_to_low;
  logic        clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, high_read_valid = 1'b0, low_write_ready = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] high_read_data = '0;
  logic        cmd_ready, high_read_req, low_write_valid, cmd_done;
  logic [15:0] high_read_addr;
  logic [7:0]  low_write_data;
  int checks = 0, failures = 0, beat_count = 0, done_count = 0, rd_count = 0, lat = 1;
  bit rand_ready = 0;
  logic [7:0]  exp_beats[$];
  logic [15:0] exp_rd[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = '0;

  high_to_low dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .high_read_req(high_read_req), .high_read_addr(high_read_addr),
    .high_read_valid(high_read_valid), .high_read_data(high_read_data), .low_write_valid(low_write_valid),
    .low_write_ready(low_write_ready), .low_write_data(low_write_data), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return a == 16'h1234 ? 32'hDDCCBBAA : {a ^ 16'hBEEF, a + 16'h0101};
  endfunction

  task automatic push_expected(input logic [15:0] a, input logic [7:0] l);
    logic [15:0] wa;
    logic [31:0] w;
    if (l == 8'd0) return;
    exp_beats.push_back(8'hA5);
    exp_beats.push_back(a[7:0]);
    exp_beats.push_back(a[15:8]);
    exp_beats.push_back(l);
    for (int i = 0; i < int'(l); i++) begin
      wa = a + 16'(i);
      exp_rd.push_back(wa);
      w = mem_word(wa);
      for (int b = 0; b < 4; b++) exp_beats.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [7:0] l);
    int n = 0;
    push_expected(a, l);
    @(negedge clk);
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_count < target && n < budget) begin @(negedge clk); #1; n++; end
    checks++;
    if (done_count < target) begin failures++; $display("FAIL %s_done_timeout: done_count=%0d required %0d", name, done_count, target); end
    checks++;
    if (exp_beats.size() != 0 || exp_rd.size() != 0) begin
      failures++; $display("FAIL %s_drain: beats_left=%0d reads_left=%0d required 0/0", name, exp_beats.size(), exp_rd.size());
    end
  endtask

  // memory model: checks each read strobe, answers after lat cycles
  initial begin
    logic [15:0] ra, ea;
    forever begin
      @(negedge clk);
      if (rst_n && high_read_req) begin
        ra = high_read_addr; rd_count++; checks++;
        if (exp_rd.size() == 0) begin failures++; $display("FAIL read_addr: unexpected read at %h", ra); end
        else begin
          ea = exp_rd.pop_front();
          if (ra !== ea) begin failures++; $display("FAIL read_addr: got %h required %h", ra, ea); end
        end
        @(negedge clk);
        checks++;
        if (high_read_req !== 1'b0) begin failures++; $display("FAIL read_strobe: high_read_req=%b one cycle later, required 0", high_read_req); end
        repeat (lat - 1) @(negedge clk);
        high_read_valid = 1'b1; high_read_data = mem_word(ra);
        @(negedge clk);
        high_read_valid = 1'b0; high_read_data = '0;
      end
    end
  end

  // downstream ready: constant 1 or 50% random, changed just after the rising edge
  initial forever begin
    @(posedge clk); #1;
    low_write_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // beat monitor: scoreboard pop on every accepted beat, stability while stalled, done pulse count
  always @(negedge clk) begin
    if (!rst_n) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        checks++;
        if (low_write_valid !== 1'b1 || low_write_data !== pd) begin
          failures++; $display("FAIL stall_stable: valid=%b data=%h required 1/%h", low_write_valid, low_write_data, pd);
        end
      end
      if (low_write_valid && low_write_ready) begin
        beat_count++; checks++;
        if (exp_beats.size() == 0) begin failures++; $display("FAIL beat: unexpected beat %h", low_write_data); end
        else if (low_write_data !== exp_beats[0]) begin
          failures++; $display("FAIL beat: got %h required %h", low_write_data, exp_beats.pop_front());
        end else void'(exp_beats.pop_front());
      end
      if (cmd_done) done_count++;
      pv = low_write_valid; pr = low_write_ready; pd = low_write_data;
    end
  end

  task automatic test_reset(input string name);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL %s_cmd_ready: got %b required 1", name, cmd_ready); end
    if (high_read_req !== 1'b0) begin failures++; $display("FAIL %s_read_req: got %b required 0", name, high_read_req); end
    if (high_read_addr !== 16'h0) begin failures++; $display("FAIL %s_read_addr: got %h required 0000", name, high_read_addr); end
    if (low_write_valid !== 1'b0) begin failures++; $display("FAIL %s_wr_valid: got %b required 0", name, low_write_valid); end
    if (low_write_data !== 8'h0) begin failures++; $display("FAIL %s_wr_data: got %h required 00", name, low_write_data); end
    if (cmd_done !== 1'b0) begin failures++; $display("FAIL %s_cmd_done: got %b required 0", name, cmd_done); end
    exp_beats.delete(); exp_rd.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n = 0, b0 = beat_count, d0 = done_count, r0 = rd_count;
    lat = 1;
    send_cmd(16'h1234, 8'd1);
    checks++;
    if (low_write_valid !== 1'b1 || low_write_data !== 8'hA5) begin
      failures++; $display("FAIL single_first_beat: valid=%b data=%h required 1/a5", low_write_valid, low_write_data);
    end
    while (!cmd_done && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n != 10) begin failures++; $display("FAIL single_latency: cmd_done after %0d cycles, required 10", n); end
    #1;
    wait_done(d0 + 1, 50, "single");
    repeat (3) @(negedge clk);
    checks += 3;
    if (beat_count - b0 != 8) begin failures++; $display("FAIL single_beats: got %0d required 8", beat_count - b0); end
    if (rd_count - r0 != 1) begin failures++; $display("FAIL single_reads: got %0d required 1", rd_count - r0); end
    if (done_count - d0 != 1) begin failures++; $display("FAIL single_done_once: got %0d required 1", done_count - d0); end
  endtask

  task automatic test_multi();
    int b0 = beat_count, d0 = done_count, r0 = rd_count;
    lat = 4;
    send_cmd(16'h0010, 8'd3);
    wait_done(d0 + 1, 300, "multi");
    checks += 2;
    if (beat_count - b0 != 16) begin failures++; $display("FAIL multi_beats: got %0d required 16", beat_count - b0); end
    if (rd_count - r0 != 3) begin failures++; $display("FAIL multi_reads: got %0d required 3", rd_count - r0); end
  endtask

  task automatic test_wrap();
    int r0 = rd_count, d0 = done_count;
    lat = 2;
    send_cmd(16'hFFFF, 8'd2);
    wait_done(d0 + 1, 300, "wrap");
    checks++;
    if (rd_count - r0 != 2) begin failures++; $display("FAIL wrap_reads: got %0d required 2", rd_count - r0); end
  endtask

  task automatic test_backpressure();
    int b0 = beat_count, d0 = done_count;
    lat = 3;
    rand_ready = 1;
    send_cmd(16'h2468, 8'd4);
    wait_done(d0 + 1, 2000, "backpressure");
    rand_ready = 0;
    checks++;
    if (beat_count - b0 != 20) begin failures++; $display("FAIL backpressure_beats: got %0d required 20", beat_count - b0); end
  endtask

  task automatic test_null_busy();
    int n = 0, b0 = beat_count, d0 = done_count;
    bit seen = 0;
    lat = 2;
    send_cmd(16'h4444, 8'd0);
    checks += 2;
    if (cmd_done !== 1'b1) begin failures++; $display("FAIL null_done: got %b required 1", cmd_done); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL null_ready_in_done: got %b required 0", cmd_ready); end
    @(negedge clk);
    checks += 3;
    if (cmd_done !== 1'b0) begin failures++; $display("FAIL null_done_pulse: got %b required 0", cmd_done); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL null_ready_after: got %b required 1", cmd_ready); end
    if (beat_count != b0) begin failures++; $display("FAIL null_beats: got %0d required 0", beat_count - b0); end
    send_cmd(16'h0100, 8'd1);
    push_expected(16'h0200, 8'd1);
    cmd_addr = 16'h0200; cmd_len = 8'd1; cmd_valid = 1'b1;
    while (!seen && n < 200) begin
      @(negedge clk); n++; checks++;
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL busy_hold: cmd_ready=%b at cycle %0d, required 0", cmd_ready, n); end
      seen = cmd_done;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL busy_done_timeout: cmd_done=0 required 1"); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL busy_release: cmd_ready=%b required 1", cmd_ready); end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(d0 + 3, 200, "busy");
    checks++;
    if (beat_count - b0 != 16) begin failures++; $display("FAIL busy_beats: got %0d required 16", beat_count - b0); end
  endtask

  task automatic test_reset_mid(input bit in_shift);
    int n = 0, b0 = beat_count, d0, r0;
    lat = in_shift ? 1 : 8;
    send_cmd(in_shift ? 16'h0600 : 16'h0500, 8'd2);
    if (in_shift) while (beat_count < b0 + 6 && n < 200) begin @(negedge clk); #2; n++; end
    else begin
      while (!high_read_req && n < 200) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
    end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL reset_mid_reach: target state not reached in %0d cycles", n); end
    test_reset(in_shift ? "reset_shift" : "reset_rd_wait");
    b0 = beat_count; d0 = done_count; r0 = rd_count;
    repeat (20) @(negedge clk);
    #1;
    checks += 4;
    if (beat_count != b0) begin failures++; $display("FAIL reset_residual_beats: got %0d required 0", beat_count - b0); end
    if (rd_count != r0) begin failures++; $display("FAIL reset_residual_reads: got %0d required 0", rd_count - r0); end
    if (done_count != d0) begin failures++; $display("FAIL reset_residual_done: got %0d required 0", done_count - d0); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_after_reset();
    int b0 = beat_count, d0 = done_count;
    lat = 1;
    send_cmd(16'h0777, 8'd1);
    wait_done(d0 + 1, 100, "after_reset");
    checks++;
    if (beat_count - b0 != 8) begin failures++; $display("FAIL after_reset_beats: got %0d required 8", beat_count - b0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #3;
    test_reset("por");
    test_single();
    test_multi();
    test_wrap();
    test_backpressure();
    test_null_busy();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
